// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the instruction memory port
// and the decode stage: memory address/data, redirect, halt and decode handshake.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] imem_address;
    logic [DATA_W-1:0] imem_read_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              halted;
    logic              misalign_err;

    modport master (
        output imem_address,
        input  imem_read_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        output halted,
        output misalign_err
    );

    modport slave (
        input  imem_address,
        output imem_read_data,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        input  halted,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the async-read
// instruction memory and buffers {instr, pc} toward decode.
module fetch_sequencer #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int RESET_PC   = 0,
    parameter int PC_STEP    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ONE_C = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] RST_PC_C = ADDR_W'(RESET_PC);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              misalign_q;
    logic              not_empty;
    logic              pop;
    logic              push;

    // Handshake qualifiers; a full FIFO still accepts a push when the head pops.
    always_comb begin
        not_empty = (count != '0);
        pop  = not_empty & bus.instr_ready;
        push = (state == RUN) & ~bus.halt & ~bus.redirect_valid
             & ((count < DEPTH_C) | pop);
    end

    // PC, FIFO pointers, run/halt state and the sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RST_PC_C;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            state      <= RUN;
            misalign_q <= 1'b0;
        end else begin
            state <= bus.halt ? HALTED : RUN;
            if (bus.redirect_valid) begin
                pc     <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    misalign_q <= 1'b1;
                end
            end else begin
                if (push) begin
                    pc     <= pc + STEP_C;
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + ONE_C;
                    2'b01:   count <= count - ONE_C;
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage; entries are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_data[wr_ptr] <= bus.imem_read_data;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

    // Head is zeroed when empty so decode never sees stale words.
    always_comb begin
        bus.imem_address = pc;
        bus.instr_valid  = not_empty;
        bus.instr        = not_empty ? fifo_data[rd_ptr] : '0;
        bus.instr_pc     = not_empty ? fifo_pc[rd_ptr] : '0;
        bus.halted       = (state == HALTED);
        bus.misalign_err = misalign_q;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: reference model feeds a
// scoreboard queue, plus directed checks from the fetch scenarios.
module tb_fetch_sequencer;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic reset;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [512];
    assign bus.imem_read_data = mem[bus.imem_address[10:2]];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard
    logic [DATA_W+ADDR_W-1:0] q [$];
    logic [ADDR_W-1:0] m_pc;
    logic m_halted, m_err, armed;
    logic m_pop, m_push;

    initial armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_pc     = '0;
            m_halted = 1'b0;
            m_err    = 1'b0;
            armed    = 1'b1;
        end else if (armed) begin
            m_pop  = (q.size() != 0) && bus.instr_ready;
            m_push = !m_halted && !bus.halt && !bus.redirect_valid
                   && ((q.size() < DEPTH) || m_pop);
            if (bus.redirect_valid) begin
                q.delete();
                m_pc = {bus.redirect_pc[10:2], 2'b00};
                if (bus.redirect_pc[1:0] != 2'b00) m_err = 1'b1;
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) begin
                    q.push_back({mem[m_pc[10:2]], m_pc});
                    m_pc = m_pc + 11'd4;
                end
            end
            m_halted = bus.halt;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("sb_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("sb_pc", 32'(bus.instr_pc), 32'(q[0][ADDR_W-1:0]));
                chk("sb_instr", bus.instr, q[0][DATA_W+ADDR_W-1:ADDR_W]);
            end else begin
                chk("sb_empty_instr", bus.instr, 32'd0);
                chk("sb_empty_pc", 32'(bus.instr_pc), 32'd0);
            end
            chk("sb_addr", 32'(bus.imem_address), 32'(m_pc));
            chk("sb_halted", 32'(bus.halted), 32'(m_halted));
            chk("sb_misalign", 32'(bus.misalign_err), 32'(m_err));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic head(input string tag, input logic [10:0] pc,
                        input logic [31:0] ins);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_pc"}, 32'(bus.instr_pc), 32'(pc));
        chk({tag, "_instr"}, bus.instr, ins);
    endtask

    task automatic redirect(input logic [10:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | i;
        mem[0]  = 32'h0050_0113;
        mem[1]  = 32'h00C0_0193;
        mem[2]  = 32'hFF71_8393;
        mem[10] = 32'h0023_A233;
        mem[18] = 32'h0091_0133;

        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        bus.instr_ready    = 1'b1;
        tick(2);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_addr", 32'(bus.imem_address), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        reset = 1'b0;

        // Sequential stream
        tick();
        head("seq0", 11'h000, 32'h0050_0113);
        tick();
        head("seq1", 11'h004, 32'h00C0_0193);
        tick();
        head("seq2", 11'h008, 32'hFF71_8393);

        // Backpressure
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        tick(5);
        head("bp_hold", 11'h000, 32'h0050_0113);
        chk("bp_addr", 32'(bus.imem_address), 32'h008);
        bus.instr_ready = 1'b1;
        tick();
        head("bp_rel0", 11'h004, 32'h00C0_0193);
        tick();
        head("bp_rel1", 11'h008, 32'hFF71_8393);

        // Redirect while full
        bus.instr_ready = 1'b0;
        tick(2);
        redirect(11'h048);
        chk("rd_flush", 32'(bus.instr_valid), 32'd0);
        chk("rd_addr", 32'(bus.imem_address), 32'h048);
        tick();
        head("rd_tgt", 11'h048, 32'h0091_0133);
        chk("rd_misalign", 32'(bus.misalign_err), 32'd0);
        bus.instr_ready = 1'b1;

        // Misaligned target
        redirect(11'h02A);
        chk("mis_err", 32'(bus.misalign_err), 32'd1);
        chk("mis_addr", 32'(bus.imem_address), 32'h028);
        tick();
        head("mis_tgt", 11'h028, 32'h0023_A233);
        redirect(11'h100);
        chk("mis_sticky_rd", 32'(bus.misalign_err), 32'd1);

        // Halt with two buffered entries
        bus.instr_ready = 1'b0;
        tick(3);
        bus.halt        = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        chk("halt_state", 32'(bus.halted), 32'd1);
        head("halt_drain", 11'h104, 32'hA000_0041);
        tick();
        chk("halt_empty", 32'(bus.instr_valid), 32'd0);
        chk("halt_addr", 32'(bus.imem_address), 32'h108);
        tick(3);
        chk("halt_addr_held", 32'(bus.imem_address), 32'h108);
        chk("mis_sticky_halt", 32'(bus.misalign_err), 32'd1);
        bus.halt = 1'b0;
        tick();
        chk("resume_state", 32'(bus.halted), 32'd0);
        tick();
        head("resume", 11'h108, 32'hA000_0042);

        // PC wrap
        redirect(11'h7FC);
        tick();
        head("wrap0", 11'h7FC, 32'hA000_01FF);
        tick();
        head("wrap1", 11'h000, 32'h0050_0113);

        // Reset with full FIFO
        bus.instr_ready = 1'b0;
        tick(2);
        reset = 1'b1;
        tick();
        chk("rst2_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst2_addr", 32'(bus.imem_address), 32'd0);
        chk("rst2_misalign", 32'(bus.misalign_err), 32'd0);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
